pipe_mux_reg: RTL and testbench

//  Parametrised N-way datapath selector with a registered output stage, for the

---
 rtl/pipe_mux_reg_if.sv | 35 +++
 rtl/pipe_mux_reg.sv | 77 +++++++
 tb/tb_pipe_mux_reg.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mux_reg_if.sv
// pipe_mux_reg_if
//   Bundles the datapath-selector bus of pipe_mux_reg.
//   master : drives data_i / select_i / valid_i / stall_i / flush_i,
//            observes mux_o / data_o / valid_o / sel_err_o / stall_cnt_o.
//   slave  : the selector itself (the reverse directions).
//   Qualifier semantics: valid_i marks the current selection as a real
//   instruction, and valid_o marks data_o as one. There is no ready signal.
//   Back-pressure comes only from stall_i, and flush_i turns the stage into a bubble.
interface pipe_mux_reg_if #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 4
);
  logic [NUM_IN*SIZE-1:0] data_i;
  logic [SEL_W-1:0]       select_i;
  logic                   valid_i;
  logic                   stall_i;
  logic                   flush_i;
  logic [SIZE-1:0]        mux_o;
  logic [SIZE-1:0]        data_o;
  logic                   valid_o;
  logic                   sel_err_o;
  logic [CNT_W-1:0]       stall_cnt_o;

  modport master (
    output data_i, select_i, valid_i, stall_i, flush_i,
    input  mux_o, data_o, valid_o, sel_err_o, stall_cnt_o
  );

  modport slave (
    input  data_i, select_i, valid_i, stall_i, flush_i,
    output mux_o, data_o, valid_o, sel_err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg
//   N-way forwarding-source select fused with the following pipeline register.
//   It supports stall hold, flush-to-bubble, a valid bit, illegal-select
//   detection and a saturating stall-run counter. A combinational mux output
//   is also provided, and it falls back to RESET_VAL for out-of-range selects.
// Ports
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-low (release synchronous to clk_i)
//   bus   : pipe_mux_reg_if.slave
//     data_i      packed inputs, input k = data_i[k*SIZE +: SIZE]
//     select_i    binary index of the input to pass
//     valid_i     selection carries a real instruction
//     stall_i     hold the register contents
//     flush_i     replace the register contents with a bubble
//     mux_o       combinational selected input
//     data_o      registered selected input
//     valid_o     data_o holds a real instruction
//     sel_err_o   last load used an out-of-range select with valid_i=1
//     stall_cnt_o consecutive stalled cycles, saturating
module pipe_mux_reg #(
  parameter int              SIZE      = 32,
  parameter int              NUM_IN    = 4,
  parameter int              SEL_W     = 2,
  parameter int              CNT_W     = 4,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input logic            clk_i,
  input logic            rst_i,
  pipe_mux_reg_if.slave  bus
);

  logic [SIZE-1:0] mux_val;
  logic            sel_illegal;

  // Selects no input for an illegal or unknown select, so the output
  // defaults to RESET_VAL and never holds a stale value.
  always_comb begin
    mux_val = RESET_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.select_i == SEL_W'(k)) begin
        mux_val = bus.data_i[k*SIZE +: SIZE];
      end
    end
  end

  // This is constant-false when NUM_IN fills the whole select range.
  assign sel_illegal = (32'(bus.select_i) >= 32'(NUM_IN));

  assign bus.mux_o = mux_val;

  // Priority per edge: flush > stall > load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.data_o      <= RESET_VAL;
      bus.valid_o     <= 1'b0;
      bus.sel_err_o   <= 1'b0;
      bus.stall_cnt_o <= '0;
    end else if (bus.flush_i) begin
      bus.data_o      <= RESET_VAL;
      bus.valid_o     <= 1'b0;
      bus.sel_err_o   <= 1'b0;
      bus.stall_cnt_o <= '0;
    end else if (bus.stall_i) begin
      // data_o, valid_o and sel_err_o hold. The counter saturates and does not wrap.
      if (bus.stall_cnt_o != {CNT_W{1'b1}}) begin
        bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
      end
    end else begin
      bus.data_o      <= mux_val;
      bus.valid_o     <= bus.valid_i;
      // AND with valid_i first, so an X select on a bubble cannot raise the flag.
      bus.sel_err_o   <= bus.valid_i & sel_illegal;
      bus.stall_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_mux_reg.sv
module tb_pipe_mux_reg;
  localparam int SIZE  = 32;
  localparam int CNT_W = 4;
  // Scoreboard entry: {skip_data, data, valid, sel_err, stall_cnt}
  localparam int W = 1 + SIZE + 1 + 1 + CNT_W;

  logic clk_i;
  logic rst_i;

  pipe_mux_reg_if #(.SIZE(SIZE), .NUM_IN(4), .SEL_W(2), .CNT_W(CNT_W)) bus4 ();
  pipe_mux_reg_if #(.SIZE(SIZE), .NUM_IN(3), .SEL_W(2), .CNT_W(CNT_W)) bus3 ();

  pipe_mux_reg #(.SIZE(SIZE), .NUM_IN(4), .SEL_W(2), .CNT_W(CNT_W)) dut4 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus4.slave)
  );

  pipe_mux_reg #(.SIZE(SIZE), .NUM_IN(3), .SEL_W(2), .CNT_W(CNT_W)) dut3 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus3.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- stimulus state / model ----------------
  logic [SIZE-1:0]  in_data [4];
  logic [SIZE-1:0]  m_data  [2];
  logic             m_valid [2];
  logic             m_err   [2];
  logic [CNT_W-1:0] m_cnt   [2];
  logic [W-1:0]     exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int num_in_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d]  = '0;
      m_valid[d] = 1'b0;
      m_err[d]   = 1'b0;
      m_cnt[d]   = '0;
    end
  endtask

  task automatic drive_bus(input logic [1:0] sel, input logic v, input logic st, input logic fl);
    bus4.data_i   = {in_data[3], in_data[2], in_data[1], in_data[0]};
    bus3.data_i   = {in_data[2], in_data[1], in_data[0]};
    bus4.select_i = sel;
    bus3.select_i = sel;
    bus4.valid_i  = v;
    bus3.valid_i  = v;
    bus4.stall_i  = st;
    bus3.stall_i  = st;
    bus4.flush_i  = fl;
    bus3.flush_i  = fl;
  endtask

  task automatic check_outputs_now(input string tag);
    check({tag, " dut4 data"},  64'(bus4.data_o),      64'(m_data[0]));
    check({tag, " dut4 valid"}, 64'(bus4.valid_o),     64'(m_valid[0]));
    check({tag, " dut4 err"},   64'(bus4.sel_err_o),   64'(m_err[0]));
    check({tag, " dut4 cnt"},   64'(bus4.stall_cnt_o), 64'(m_cnt[0]));
    check({tag, " dut3 data"},  64'(bus3.data_o),      64'(m_data[1]));
    check({tag, " dut3 valid"}, 64'(bus3.valid_o),     64'(m_valid[1]));
    check({tag, " dut3 err"},   64'(bus3.sel_err_o),   64'(m_err[1]));
    check({tag, " dut3 cnt"},   64'(bus3.stall_cnt_o), 64'(m_cnt[1]));
  endtask

  // One clock cycle: drive at negedge, check mux_o, push expected register
  // state, then pop and compare after the rising edge.
  task automatic step(input string tag, input int sel, input logic v,
                      input logic st, input logic fl, input logic xsel);
    logic [SIZE-1:0] exp_mux;
    logic [W-1:0]    e;
    logic [SIZE-1:0] got_d;
    logic            got_v, got_e;
    logic [CNT_W-1:0] got_c;
    @(negedge clk_i);
    drive_bus(xsel ? 2'bxx : 2'(sel), v, st, fl);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_mux = (sel < num_in_of(d)) ? in_data[sel] : '0;
      if (!xsel) begin
        if (d == 0) check({tag, " dut4 mux"}, 64'(bus4.mux_o), 64'(exp_mux));
        else        check({tag, " dut3 mux"}, 64'(bus3.mux_o), 64'(exp_mux));
      end
      if (fl) begin
        m_data[d] = '0; m_valid[d] = 1'b0; m_err[d] = 1'b0; m_cnt[d] = '0;
      end else if (st) begin
        if (m_cnt[d] != 4'hF) m_cnt[d] = m_cnt[d] + 1'b1;
      end else begin
        m_data[d]  = exp_mux;
        m_valid[d] = v;
        m_err[d]   = v && (sel >= num_in_of(d));
        m_cnt[d]   = '0;
      end
      exp_q.push_back({xsel && !fl && !st, m_data[d], m_valid[d], m_err[d], m_cnt[d]});
    end
    @(posedge clk_i);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (exp_q.size() == 0) begin
        check({tag, " queue empty"}, 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        if (d == 0) begin
          got_d = bus4.data_o; got_v = bus4.valid_o; got_e = bus4.sel_err_o; got_c = bus4.stall_cnt_o;
        end else begin
          got_d = bus3.data_o; got_v = bus3.valid_o; got_e = bus3.sel_err_o; got_c = bus3.stall_cnt_o;
        end
        if (!e[W-1]) check($sformatf("%s d%0d data", tag, d), 64'(got_d), 64'(e[W-2 -: SIZE]));
        check($sformatf("%s d%0d valid", tag, d), 64'(got_v), 64'(e[CNT_W+1]));
        check($sformatf("%s d%0d err", tag, d),   64'(got_e), 64'(e[CNT_W]));
        check($sformatf("%s d%0d cnt", tag, d),   64'(got_c), 64'(e[CNT_W-1:0]));
      end
    end
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) in_data[k] = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // 1: reset with random inputs, then a first load
    rst_i = 1'b0;
    randomize_inputs();
    drive_bus(2'($urandom_range(3, 0)), 1'b1, 1'($urandom_range(1, 0)), 1'b0);
    model_reset();
    #12;
    check_outputs_now("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    in_data[2] = 32'hCAFE0002;
    step("first_load", 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: sweep the selects
    for (int k = 0; k < 4; k++) in_data[k] = 32'h1000_0000 + k;
    for (int s = 0; s < 4; s++) step($sformatf("sweep%0d", s), s, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: a 20-cycle stall with changing inputs. The counter saturates at 15.
    in_data[1] = 32'hA5A5A5A5;
    step("stall_load", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      step($sformatf("stall%0d", i), $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'b1, 1'b0, 1'b0);
    end
    step("stall_release", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: flush wins over a simultaneous stall
    step("pre_flush_stall", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("flush_stall", 3, 1'b1, 1'b1, 1'b1, 1'b0);

    // 5: illegal select on the 3-input instance, with and without valid
    randomize_inputs();
    step("illegal_v1", 3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("illegal_hold", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("illegal_v0", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("illegal_again", 3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("legal_clear", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("illegal_flush_pre", 3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("illegal_flush", 3, 1'b1, 1'b0, 1'b1, 1'b0);

    // An unknown select on a bubble must leave valid, err and cnt clean.
    step("xsel", 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random mix of actions
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      step($sformatf("rand%0d", i), $urandom_range(3, 0), 1'($urandom_range(1, 0)),
           1'($urandom_range(3, 0) == 0), 1'($urandom_range(7, 0) == 0), 1'b0);
    end

    // 6: asynchronous reset between edges, in the middle of a stall
    in_data[3] = 32'h5A5A_0003;
    step("async_load", 3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("async_stall%0d", i), 0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    model_reset();
    #1;
    check_outputs_now("async_reset");
    #2;
    rst_i = 1'b1;
    step("after_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    check("queue drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
